// File: rtl/core_pkg.sv
// Shared constants and helpers for the core register file.
package core_pkg;

  localparam int DATA_W = 32;
  localparam int IPSR_W = 6;
  localparam int IDX_W  = 4;
  localparam int NUM_GPR = 13;

  localparam logic [IDX_W-1:0] REG_SP = 4'd13;
  localparam logic [IDX_W-1:0] REG_LR = 4'd14;
  localparam logic [IDX_W-1:0] REG_PC = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // SP is always word aligned.
  function automatic logic [DATA_W-1:0] align_sp(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1:2], 2'b00};
  endfunction

  // PC is always halfword aligned.
  function automatic logic [DATA_W-1:0] align_pc(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/gpr_bank.sv
// R0-R12 storage: one write port, three combinational read ports.
// Indices outside 0-12 read as zero; the top handles SP/LR/PC.
module gpr_bank
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr_a,
  input  logic [IDX_W-1:0]  i_raddr_b,
  input  logic [IDX_W-1:0]  i_raddr_c,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_rdata_c
);

  logic [DATA_W-1:0] r_gpr [NUM_GPR];

  // Clear on reset, otherwise write the addressed register when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
    end else if (i_we && (i_waddr < IDX_W'(NUM_GPR))) begin
      r_gpr[i_waddr] <= i_wdata;
    end
  end

  // Three independent combinational read ports from stored state.
  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    o_rdata_c = '0;
    if (i_raddr_a < IDX_W'(NUM_GPR)) o_rdata_a = r_gpr[i_raddr_a];
    if (i_raddr_b < IDX_W'(NUM_GPR)) o_rdata_b = r_gpr[i_raddr_b];
    if (i_raddr_c < IDX_W'(NUM_GPR)) o_rdata_c = r_gpr[i_raddr_c];
  end

endmodule

// File: rtl/core_register_file.sv
// Architectural register state of the core: R0-R12 bank, SP/LR/PC,
// APSR flags, IPSR and PRIMASK, with index-mapped read/write ports.
module core_register_file
  import core_pkg::*;
#(
  parameter logic [31:0] SP_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_sp,
  input  logic              ld_lr,
  input  logic              ld_pc,
  input  logic              ld_rd,
  input  logic              ld_apsr,
  input  logic              ld_ipsr,
  input  logic              ld_primask,
  input  logic [DATA_W-1:0] w_sp,
  input  logic [DATA_W-1:0] w_lr,
  input  logic [DATA_W-1:0] w_pc,
  input  logic [DATA_W-1:0] w_rd,
  input  logic [IDX_W-1:0]  addr_rn,
  input  logic [IDX_W-1:0]  addr_rm,
  input  logic [IDX_W-1:0]  addr_rd,
  input  logic [3:0]        w_flags,
  input  logic [IPSR_W-1:0] w_ipsr,
  input  logic              w_pmask,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] lr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] rn,
  output logic [DATA_W-1:0] rm,
  output logic [DATA_W-1:0] rd,
  output logic [3:0]        flags,
  output logic [IPSR_W-1:0] ipsr,
  output logic              pmask
);

  logic [DATA_W-1:0] r_sp;
  logic [DATA_W-1:0] r_lr;
  logic [DATA_W-1:0] r_pc;
  logic [3:0]        r_flags;
  logic [IPSR_W-1:0] r_ipsr;
  logic              r_pmask;

  logic              w_rd_is_sp;
  logic              w_rd_is_lr;
  logic              w_rd_is_pc;
  logic              w_gpr_we;
  logic [DATA_W-1:0] w_bank_rn;
  logic [DATA_W-1:0] w_bank_rm;
  logic [DATA_W-1:0] w_bank_rd;

  // Decode which special register, if any, the Rd write port aims at.
  always_comb begin
    w_rd_is_sp = ld_rd && (addr_rd == REG_SP);
    w_rd_is_lr = ld_rd && (addr_rd == REG_LR);
    w_rd_is_pc = ld_rd && (addr_rd == REG_PC);
    w_gpr_we   = ld_rd && (addr_rd < IDX_W'(NUM_GPR));
  end

  gpr_bank u_gpr_bank (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_gpr_we),
    .i_waddr   (addr_rd),
    .i_wdata   (w_rd),
    .i_raddr_a (addr_rn),
    .i_raddr_b (addr_rm),
    .i_raddr_c (addr_rd),
    .o_rdata_a (w_bank_rn),
    .o_rdata_b (w_bank_rm),
    .o_rdata_c (w_bank_rd)
  );

  // SP/LR/PC: dedicated load beats an Rd write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= align_sp(SP_RESET);
      r_lr <= '0;
      r_pc <= align_pc(PC_RESET);
    end else begin
      if (ld_sp)           r_sp <= align_sp(w_sp);
      else if (w_rd_is_sp) r_sp <= align_sp(w_rd);

      if (ld_lr)           r_lr <= w_lr;
      else if (w_rd_is_lr) r_lr <= w_rd;

      if (ld_pc)           r_pc <= align_pc(w_pc);
      else if (w_rd_is_pc) r_pc <= align_pc(w_rd);
    end
  end

  // Status registers load independently; IPSR is stored without range check.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
      r_ipsr  <= '0;
      r_pmask <= 1'b0;
    end else begin
      if (ld_apsr)    r_flags <= w_flags;
      if (ld_ipsr)    r_ipsr  <= w_ipsr;
      if (ld_primask) r_pmask <= w_pmask;
    end
  end

  // Index mux for the read ports; PC reads back as stored, no offset.
  always_comb begin
    unique case (addr_rn)
      REG_SP:  rn = r_sp;
      REG_LR:  rn = r_lr;
      REG_PC:  rn = r_pc;
      default: rn = w_bank_rn;
    endcase
    unique case (addr_rm)
      REG_SP:  rm = r_sp;
      REG_LR:  rm = r_lr;
      REG_PC:  rm = r_pc;
      default: rm = w_bank_rm;
    endcase
    unique case (addr_rd)
      REG_SP:  rd = r_sp;
      REG_LR:  rd = r_lr;
      REG_PC:  rd = r_pc;
      default: rd = w_bank_rd;
    endcase
  end

  assign sp    = r_sp;
  assign lr    = r_lr;
  assign pc    = r_pc;
  assign flags = r_flags;
  assign ipsr  = r_ipsr;
  assign pmask = r_pmask;

endmodule

// File: tb/tb_core_register_file.sv
// Directed bench for core_register_file with hand-computed expectations.
module tb_core_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask;
  logic [31:0] w_sp, w_lr, w_pc, w_rd;
  logic [3:0]  addr_rn, addr_rm, addr_rd;
  logic [3:0]  w_flags;
  logic [5:0]  w_ipsr;
  logic        w_pmask;
  logic [31:0] sp, lr, pc, rn, rm, rd;
  logic [3:0]  flags;
  logic [5:0]  ipsr;
  logic        pmask;

  int n_tests = 0;
  int n_fail  = 0;

  core_register_file dut (
    .clk(clk), .rst(rst),
    .ld_sp(ld_sp), .ld_lr(ld_lr), .ld_pc(ld_pc), .ld_rd(ld_rd),
    .ld_apsr(ld_apsr), .ld_ipsr(ld_ipsr), .ld_primask(ld_primask),
    .w_sp(w_sp), .w_lr(w_lr), .w_pc(w_pc), .w_rd(w_rd),
    .addr_rn(addr_rn), .addr_rm(addr_rm), .addr_rd(addr_rd),
    .w_flags(w_flags), .w_ipsr(w_ipsr), .w_pmask(w_pmask),
    .sp(sp), .lr(lr), .pc(pc), .rn(rn), .rm(rm), .rd(rd),
    .flags(flags), .ipsr(ipsr), .pmask(pmask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_loads();
    ld_sp = 0; ld_lr = 0; ld_pc = 0; ld_rd = 0;
    ld_apsr = 0; ld_ipsr = 0; ld_primask = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr_loads();
    w_sp = '0; w_lr = '0; w_pc = '0; w_rd = '0;
    addr_rn = 0; addr_rm = 0; addr_rd = 0;
    w_flags = '0; w_ipsr = '0; w_pmask = 1'b0;
    step();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_sp", sp, 32'h0);
    chk("rst_lr", lr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_rn", rn, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_ipsr", {26'h0, ipsr}, 32'h0);
    chk("rst_pmask", {31'h0, pmask}, 32'h0);

    // Dedicated loads with alignment
    ld_sp = 1; ld_lr = 1; ld_pc = 1;
    w_sp = 32'h0000_0002; w_lr = 32'hFF00_FF03; w_pc = 32'h0403_0102;
    step();
    clr_loads();
    chk("ded_sp", sp, 32'h0000_0000);
    chk("ded_lr", lr, 32'hFF00_FF03);
    chk("ded_pc", pc, 32'h0403_0102);
    ld_sp = 1; w_sp = 32'h1234_567F; ld_pc = 1; w_pc = 32'h0000_0FFF;
    step();
    clr_loads();
    chk("ded_sp_align", sp, 32'h1234_567C);
    chk("ded_pc_align", pc, 32'h0000_0FFE);

    // GPR write; no bypass before the edge
    ld_rd = 1; addr_rd = 2; w_rd = 32'h06FF_FFF2; addr_rn = 0; addr_rm = 1;
    #1;
    chk("no_bypass_rd", rd, 32'h0);
    step();
    clr_loads();
    chk("gpr_rd", rd, 32'h06FF_FFF2);
    chk("gpr_rn0", rn, 32'h0);
    chk("gpr_rm1", rm, 32'h0);
    addr_rn = 2;
    #1;
    chk("gpr_rn2", rn, 32'h06FF_FFF2);

    // R12 boundary, read back via rm
    ld_rd = 1; addr_rd = 12; w_rd = 32'hC0DE_0012;
    step();
    clr_loads();
    addr_rm = 12;
    #1;
    chk("gpr_r12", rm, 32'hC0DE_0012);
    chk("gpr_r2_kept", rn, 32'h06FF_FFF2);

    // Status loads then hold
    w_flags = 4'hF; w_ipsr = 6'h12; w_pmask = 1'b1;
    ld_apsr = 1; ld_ipsr = 1; ld_primask = 1;
    step();
    clr_loads();
    chk("st_flags", {28'h0, flags}, 32'hF);
    chk("st_ipsr", {26'h0, ipsr}, 32'h12);
    chk("st_pmask", {31'h0, pmask}, 32'h1);
    w_flags = 4'h0; w_ipsr = 6'h3F; w_pmask = 1'b0;
    step();
    chk("hold_flags", {28'h0, flags}, 32'hF);
    chk("hold_ipsr", {26'h0, ipsr}, 32'h12);
    chk("hold_pmask", {31'h0, pmask}, 32'h1);
    ld_ipsr = 1;
    step();
    clr_loads();
    chk("ipsr_63", {26'h0, ipsr}, 32'h3F);
    chk("ipsr_flags_kept", {28'h0, flags}, 32'hF);

    // Priority: dedicated SP beats Rd alias
    ld_rd = 1; addr_rd = 13; w_rd = 32'h11; ld_sp = 1; w_sp = 32'h20;
    step();
    clr_loads();
    chk("prio_sp", sp, 32'h20);
    ld_rd = 1; addr_rd = 15; w_rd = 32'h101;
    step();
    clr_loads();
    chk("alias_pc", pc, 32'h100);
    chk("alias_rd15", rd, 32'h100);
    ld_rd = 1; addr_rd = 13; w_rd = 32'h37;
    step();
    clr_loads();
    chk("alias_sp", sp, 32'h34);
    ld_rd = 1; addr_rd = 14; w_rd = 32'hAAAA_5555; ld_lr = 1; w_lr = 32'h0BAD_F00D;
    step();
    clr_loads();
    addr_rm = 14; addr_rn = 13;
    #1;
    chk("prio_lr", lr, 32'h0BAD_F00D);
    chk("rm14_lr", rm, 32'h0BAD_F00D);
    chk("rn13_sp", rn, 32'h34);

    // Reset mid-operation overrides loads
    ld_rd = 1; addr_rd = 5; w_rd = 32'h1234;
    step();
    clr_loads();
    addr_rn = 5;
    #1;
    chk("r5_pre", rn, 32'h1234);
    rst = 1; ld_rd = 1; addr_rd = 5; w_rd = 32'hDEAD; ld_sp = 1; w_sp = 32'h40;
    step();
    rst = 0;
    clr_loads();
    #1;
    chk("mid_rst_r5", rn, 32'h0);
    chk("mid_rst_sp", sp, 32'h0);
    chk("mid_rst_lr", lr, 32'h0);
    chk("mid_rst_flags", {28'h0, flags}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
